// File: rtl/disp_demux_if.sv
// Signal bundle between a scanned 7-segment source and the disp_demux receiver.
// The master drives the raw anode/segment pins; the slave returns the rebuilt digits and status.
interface disp_demux_if;
  logic [3:0] an_in;
  logic [7:0] sseg_in;
  logic [7:0] out0;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [7:0] out3;
  logic [3:0] digit_upd;
  logic       frame_pulse;
  logic       frame_valid;
  logic       active;
  logic       err_multi;

  modport master (
    output an_in, sseg_in,
    input  out0, out1, out2, out3, digit_upd, frame_pulse, frame_valid, active, err_multi
  );

  modport slave (
    input  an_in, sseg_in,
    output out0, out1, out2, out3, digit_upd, frame_pulse, frame_valid, active, err_multi
  );
endinterface

// File: rtl/disp_demux.sv
// Receiver for a 4-digit time-multiplexed active-low 7-segment scan: synchronises the pins,
// captures each digit once its pattern has been stable, and tracks frames and scan activity.
module disp_demux #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT_W     = 20
) (
  input logic         clk,
  input logic         reset,
  disp_demux_if.slave bus
);

  localparam logic [7:0]           STABLE_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0]           STABLE_EVT = 8'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX    = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] TMO_ONE    = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  // One-hot digit select for a single active-low anode; zero for blank or illegal patterns.
  function automatic logic [3:0] digit_mask(input logic [3:0] an);
    case (an)
      4'b1110: digit_mask = 4'b0001;
      4'b1101: digit_mask = 4'b0010;
      4'b1011: digit_mask = 4'b0100;
      4'b0111: digit_mask = 4'b1000;
      default: digit_mask = 4'b0000;
    endcase
  endfunction

  logic [11:0]          sync1_r;
  logic [11:0]          s_r;
  logic [11:0]          p_r;
  logic [7:0]           cnt_r;
  logic [3:0]           seen_r;
  logic [TIMEOUT_W-1:0] tmo_r;
  logic [7:0]           out_r [4];
  logic [3:0]           upd_r;
  logic                 fp_r;
  logic                 fv_r;
  logic                 act_r;
  logic                 err_r;

  logic       evt_s;
  logic       cap_s;
  logic       err_s;
  logic       frame_s;
  logic [3:0] mask_s;
  logic [3:0] seen_next_s;

  // Event detection and capture/frame decisions for the current synced value.
  always_comb begin
    evt_s       = 1'b0;
    mask_s      = digit_mask(s_r[11:8]);
    if ((s_r == p_r) && (cnt_r == STABLE_EVT)) begin
      evt_s = 1'b1;
    end else begin
      evt_s = 1'b0;
    end
    cap_s       = evt_s && (mask_s != 4'b0000);
    err_s       = evt_s && (mask_s == 4'b0000) && (s_r[11:8] != 4'hF);
    seen_next_s = seen_r | mask_s;
    frame_s     = cap_s && (seen_next_s == 4'hF);
  end

  // Two-stage synchroniser, previous-value register and stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 12'hFFF;
      s_r     <= 12'hFFF;
      p_r     <= 12'hFFF;
      cnt_r   <= 8'd0;
    end else begin
      sync1_r <= {bus.an_in, bus.sseg_in};
      s_r     <= sync1_r;
      p_r     <= s_r;
      if (s_r != p_r) begin
        cnt_r <= 8'd0;
      end else if (cnt_r != STABLE_SAT) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Digit capture, frame tracking and inactivity timeout; a capture overrides a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) out_r[i] <= 8'hFF;
      upd_r  <= 4'b0000;
      fp_r   <= 1'b0;
      fv_r   <= 1'b0;
      act_r  <= 1'b0;
      err_r  <= 1'b0;
      seen_r <= 4'b0000;
      tmo_r  <= '0;
    end else begin
      upd_r <= cap_s ? mask_s : 4'b0000;
      fp_r  <= frame_s;
      err_r <= err_s;
      if (cap_s) begin
        for (int i = 0; i < 4; i++) begin
          if (mask_s[i]) out_r[i] <= s_r[7:0];
        end
        act_r <= 1'b1;
        tmo_r <= '0;
        if (frame_s) begin
          seen_r <= 4'b0000;
          fv_r   <= 1'b1;
        end else begin
          seen_r <= seen_next_s;
        end
      end else if (tmo_r == TMO_MAX) begin
        act_r  <= 1'b0;
        fv_r   <= 1'b0;
        seen_r <= 4'b0000;
        tmo_r  <= '0;
      end else begin
        tmo_r <= tmo_r + TMO_ONE;
      end
    end
  end

  assign bus.out0        = out_r[0];
  assign bus.out1        = out_r[1];
  assign bus.out2        = out_r[2];
  assign bus.out3        = out_r[3];
  assign bus.digit_upd   = upd_r;
  assign bus.frame_pulse = fp_r;
  assign bus.frame_valid = fv_r;
  assign bus.active      = act_r;
  assign bus.err_multi   = err_r;

endmodule

// File: tb/tb_disp_demux.sv
// Randomised bench for disp_demux: a run-length reference model predicts every output each cycle.
module tb_disp_demux;
  localparam int SC = 4;
  localparam int TW = 8;

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [7:0] sseg;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_demux_if bus();
  disp_demux #(.STABLE_CYCLES(SC), .TIMEOUT_W(TW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  m_out [4];
  logic [3:0]  m_seen, m_upd;
  logic        m_fv, m_act, m_fp, m_err;
  int          m_idle, edge_n, run_len;
  logic [11:0] run_val;
  ev_t         evq[$];
  int          fp_cnt, err_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_out[i] = 8'hFF;
    m_seen = 4'h0; m_upd = 4'h0; m_fv = 1'b0; m_act = 1'b0; m_fp = 1'b0; m_err = 1'b0;
    m_idle = 0; edge_n = 0; evq.delete();
    // reset leaves the blank pattern already seen as stable for three samples
    run_val = 12'hFFF; run_len = 3;
  endtask

  // One clock edge of the model: apply any event that matures now, then account for the pin sample.
  task automatic model_edge(input logic [3:0] an, input logic [7:0] sseg);
    ev_t e;
    int d;
    bit cap;
    logic [3:0] pat;
    edge_n++;
    m_upd = 4'h0; m_fp = 1'b0; m_err = 1'b0; cap = 1'b0;
    if (evq.size() > 0 && evq[0].due == edge_n) begin
      e = evq.pop_front();
      d = -1;
      for (int i = 0; i < 4; i++) begin
        pat = ~(4'b0001 << i);
        if (e.an == pat) d = i;
      end
      if (d >= 0) begin
        cap = 1'b1;
        m_out[d] = e.sseg;
        m_upd[d] = 1'b1;
        m_act = 1'b1;
        m_idle = 0;
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
          m_fp = 1'b1; m_fv = 1'b1; m_seen = 4'h0;
        end
      end else if (e.an != 4'hF) begin
        m_err = 1'b1;
      end
    end
    if (!cap) begin
      if (m_idle == (1 << TW) - 1) begin
        m_act = 1'b0; m_fv = 1'b0; m_seen = 4'h0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if ({an, sseg} == run_val) run_len++;
    else begin
      run_val = {an, sseg};
      run_len = 1;
    end
    if (run_len == SC + 1) evq.push_back('{edge_n + 2, an, sseg});
  endtask

  task automatic check_all();
    chk("out0", bus.out0, m_out[0]);
    chk("out1", bus.out1, m_out[1]);
    chk("out2", bus.out2, m_out[2]);
    chk("out3", bus.out3, m_out[3]);
    chk("digit_upd", bus.digit_upd, m_upd);
    chk("frame_pulse", bus.frame_pulse, m_fp);
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("active", bus.active, m_act);
    chk("err_multi", bus.err_multi, m_err);
  endtask

  task automatic step(input logic [3:0] an, input logic [7:0] sseg);
    bus.an_in = an;
    bus.sseg_in = sseg;
    @(posedge clk);
    model_edge(an, sseg);
    @(negedge clk);
    check_all();
    if (bus.frame_pulse) fp_cnt++;
    if (bus.err_multi) err_cnt++;
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] sseg, input int n);
    for (int i = 0; i < n; i++) step(an, sseg);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.an_in = 4'($urandom);
      bus.sseg_in = 8'($urandom);
      @(negedge clk);
      chk("rst_out0", bus.out0, 8'hFF);
      chk("rst_out3", bus.out3, 8'hFF);
      chk("rst_upd", bus.digit_upd, 4'h0);
      chk("rst_flags", {bus.frame_pulse, bus.frame_valid, bus.active, bus.err_multi}, 4'h0);
    end
    bus.an_in = 4'hF;
    bus.sseg_in = 8'hFF;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] an;
    logic [7:0] sseg;
    int pick;
    reset = 1'b1;
    bus.an_in = 4'hF;
    bus.sseg_in = 8'hFF;
    @(negedge clk);
    do_reset();

    // single digit capture latency
    hold(4'hF, 8'hFF, 3);
    hold(4'b1110, 8'hC0, 10);
    chk("t2_out0", bus.out0, 8'hC0);

    // one full scan
    fp_cnt = 0;
    hold(4'b1110, 8'hC0, 10);
    hold(4'b1101, 8'hF9, 10);
    hold(4'b1011, 8'hA4, 10);
    hold(4'b0111, 8'hB0, 10);
    chk("t3_fp_count", fp_cnt, 1);
    chk("t3_out2", bus.out2, 8'hA4);
    chk("t3_fv", bus.frame_valid, 1'b1);

    // glitch on digit 1 is rejected, digit 0 recaptured
    hold(4'b1110, 8'hC0, 10);
    hold(4'b1101, 8'h00, 2);
    hold(4'b1110, 8'hC0, 10);
    chk("t4_out1", bus.out1, 8'hF9);

    // illegal anode pattern
    err_cnt = 0;
    hold(4'b1100, 8'h00, 10);
    chk("t5_err_count", err_cnt, 1);

    // inactivity timeout, then reset discards a partial frame
    hold(4'hF, 8'hFF, 260);
    chk("t6_active", bus.active, 1'b0);
    chk("t6_fv", bus.frame_valid, 1'b0);
    chk("t6_out3", bus.out3, 8'hB0);
    hold(4'b1110, 8'h11, 10);
    hold(4'b1101, 8'h22, 10);
    do_reset();
    fp_cnt = 0;
    hold(4'b1011, 8'h33, 10);
    hold(4'b0111, 8'h44, 10);
    chk("t6_no_frame", fp_cnt, 0);

    // randomised scan traffic with glitches, blanks and illegal patterns
    for (int seg = 0; seg < 220; seg++) begin
      pick = $urandom_range(0, 9);
      if (pick < 7) an = ~(4'b0001 << $urandom_range(0, 3));
      else if (pick == 7) an = 4'hF;
      else an = 4'($urandom);
      sseg = 8'($urandom);
      hold(an, sseg, $urandom_range(1, 12));
      if (seg == 110) hold(4'hF, 8'hFF, 300);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
